goertzel_bin_scheduler: RTL and testbench
=========================================

// Module: goertzel_bin_scheduler
// PURPOSE
//  Sequences one shared goertzel_core over up to NUM_BINS frequency bins per frame.
//  Holds a per-bin coefficient table written by the SPI main_state_machine config path.
//  On a run request it starts the core once per enabled bin and stores each T1/T2 result.
//  Results are presented on a registered readback port for the SPI side.
// PARAMETERS
//  D_W            16    coefficient / result width (fix14_16)
//  NUM_BINS       8     number of coefficient/result slots
//  BIN_BITS       3     address width, clog2(NUM_BINS)
//  TIMEOUT_CYCLES 4096  core_done watchdog limit (GOERTZEL_SCHED_TIMEOUT_EN only)
// PORTS
//  dsp_clk     in   1         sole clock, all logic rising edge
//  dsp_rst     in   1         asynchronous, active-high reset
//  cfg_we      in   1         coefficient write strobe
//  cfg_addr    in   BIN_BITS  coefficient write address
//  cfg_coeff   in   D_W       coefficient write data
//  bin_enable  in   NUM_BINS  per-bin enable mask, sampled when run is accepted
//  run         in   1         frame start request (level; accepted only in IDLE)
//  abort       in   1         cancel frame in progress
//  busy        out  1         high in any state except IDLE
//  frame_done  out  1         one-cycle pulse on frame completion
//  core_start  out  1         one-cycle start pulse to goertzel_core
//  core_coeff  out  D_W       coefficient driven to core, stable START..STORE
//  core_done   in   1         core result valid
//  core_t1     in   D_W       core T1_OUT
//  core_t2     in   D_W       core T2_OUT
//  rd_addr     in   BIN_BITS  result readback address
//  rd_t1       out  D_W       stored T1 at rd_addr, 1-cycle latency
//  rd_t2       out  D_W       stored T2 at rd_addr, 1-cycle latency
//  res_valid   out  NUM_BINS  bit n set when bin n stored this frame
//  err         out  1         sticky timeout flag (0 when macro absent)
// BEHAVIOUR
//  Reset: state IDLE; busy, frame_done, core_start, err = 0; core_coeff, rd_t1, rd_t2 = 0;
//   res_valid = 0; coeff table and result table cleared to 0.
//  FSM: IDLE -> SCAN -> START -> WAIT -> STORE -> SCAN ... -> DONE -> IDLE.
//  IDLE: run=1 latches bin_enable into mask, clears res_valid, bin index=0, go SCAN.
//  SCAN: one bin per cycle; if mask[idx] latch core_coeff=coeff[idx], go START;
//   else idx++; idx past NUM_BINS-1 -> DONE (no wrap).
//  START: core_start=1 for exactly this cycle; go WAIT.
//  WAIT: core_done sampled only here; core_done=1 -> STORE.
//  STORE: t1/t2 tables[idx] <= core_t1/core_t2; res_valid[idx]<=1; idx++; go SCAN.
//  DONE: frame_done=1 one cycle; go IDLE.
//  Latency per enabled bin: 3 cycles + core time; mask=0 -> frame_done 1+NUM_BINS+1 cycles after run.
//  run while busy: ignored. cfg_we any time: table updated next edge; an in-flight bin keeps
//   its already latched core_coeff.
//  abort (any non-IDLE state, priority over core_done): IDLE next cycle, no frame_done,
//   completed bins keep res_valid; late core_done in IDLE ignored.
//  Readback: rd_t1/rd_t2 registered from rd_addr; same-cycle STORE to rd_addr returns old value.
//  Out-of-range addresses (>= NUM_BINS): writes dropped, reads return 0.
// CONFIGURATION
//  GOERTZEL_SCHED_TIMEOUT_EN defined: WAIT counts cycles; at TIMEOUT_CYCLES without core_done
//   set err (sticky, cleared only by dsp_rst or next accepted run), skip bin (res_valid stays 0),
//   go SCAN. Undefined: no counter, WAIT waits indefinitely, err tied 0.
// TESTING
//  coeffs 0x2826,0x1882 to bins 0,1; mask 0x03; run; core model done 10 cyc after start,
//   t1=bin*0x100+1 -> 2 core_start pulses, rd bin1 = 0x0101, res_valid=0x03, one frame_done.
//  mask 0x00; run -> no core_start, frame_done 10 cycles after run (NUM_BINS=8).
//  mask 0x81 -> core_start only for bins 0 and 7; core_coeff = coeff[7] during second WAIT.
//  abort in WAIT of bin 1 of mask 0x07 -> busy low next cycle, res_valid=0x01, no frame_done.
//  run held while busy, cfg_we bin 2 mid-frame -> one frame only; bin 2 uses old coeff if latched.
//  TIMEOUT_EN, core never responds on bin 0, mask 0x03 -> err=1 after 4096 cycles, bin 1 runs, res_valid=0x02.

Source files
------------

// File: rtl/goertzel_bin_scheduler.sv
// Frame sequencer that time-shares one goertzel_core across NUM_BINS coefficient/result slots.
// Optional core_done watchdog: define GOERTZEL_SCHED_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for run; mask/err refreshed on accept
// SCAN  | test mask[idx], latch coefficient for an enabled bin
// START | core_start pulse
// WAIT  | waiting for core_done (or watchdog expiry)
// STORE | write T1/T2 result for idx
// DONE  | frame_done pulse
module goertzel_bin_scheduler #(
   parameter int D_W            = 16,
   parameter int NUM_BINS       = 8,
   parameter int BIN_BITS       = 3,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                dsp_clk,
   input  logic                dsp_rst,
   input  logic                cfg_we,
   input  logic [BIN_BITS-1:0] cfg_addr,
   input  logic [D_W-1:0]      cfg_coeff,
   input  logic [NUM_BINS-1:0] bin_enable,
   input  logic                run,
   input  logic                abort,
   output logic                busy,
   output logic                frame_done,
   output logic                core_start,
   output logic [D_W-1:0]      core_coeff,
   input  logic                core_done,
   input  logic [D_W-1:0]      core_t1,
   input  logic [D_W-1:0]      core_t2,
   input  logic [BIN_BITS-1:0] rd_addr,
   output logic [D_W-1:0]      rd_t1,
   output logic [D_W-1:0]      rd_t2,
   output logic [NUM_BINS-1:0] res_valid,
   output logic                err
);

   typedef enum logic [2:0] {IDLE, SCAN, START, WAIT, STORE, DONE} state_t;

   localparam logic [BIN_BITS:0] IDX_END  = (BIN_BITS+1)'(NUM_BINS);
   localparam logic [BIN_BITS:0] IDX_LAST = (BIN_BITS+1)'(NUM_BINS-1);

   if (TIMEOUT_CYCLES < 2 || NUM_BINS > (1 << BIN_BITS)) begin : g_bad_param
      $error("goertzel_bin_scheduler: invalid TIMEOUT_CYCLES or NUM_BINS/BIN_BITS");
   end

   state_t              state;
   logic [NUM_BINS-1:0] mask;
   // One extra bit so a store of the last bin can step past the end without wrapping.
   logic [BIN_BITS:0]   idx;
   logic [BIN_BITS-1:0] idx_lo;
   logic [D_W-1:0]      coeff_tab [NUM_BINS];
   logic [D_W-1:0]      t1_tab    [NUM_BINS];
   logic [D_W-1:0]      t2_tab    [NUM_BINS];

   assign idx_lo = idx[BIN_BITS-1:0];

`ifdef GOERTZEL_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge dsp_clk or posedge dsp_rst) begin
      if (dsp_rst) begin
         for (int i = 0; i < NUM_BINS; i++) coeff_tab[i] <= '0;
      end else if (cfg_we && (int'(cfg_addr) < NUM_BINS)) begin
         coeff_tab[cfg_addr] <= cfg_coeff;
      end
   end

   always_ff @(posedge dsp_clk or posedge dsp_rst) begin
      if (dsp_rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         core_start <= 1'b0;
         core_coeff <= '0;
         mask       <= '0;
         idx        <= '0;
         res_valid  <= '0;
         for (int i = 0; i < NUM_BINS; i++) begin
            t1_tab[i] <= '0;
            t2_tab[i] <= '0;
         end
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
         to_cnt     <= '0;
         err        <= 1'b0;
`endif
      end else begin
         core_start <= 1'b0;
         frame_done <= 1'b0;
         if (abort && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: if (run) begin
                  mask      <= bin_enable;
                  res_valid <= '0;
                  idx       <= '0;
                  busy      <= 1'b1;
                  state     <= SCAN;
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
                  err       <= 1'b0;
`endif
               end
               SCAN: begin
                  if (idx >= IDX_END) begin
                     frame_done <= 1'b1;
                     state      <= DONE;
                  end else if (mask[idx_lo]) begin
                     core_coeff <= coeff_tab[idx_lo];
                     core_start <= 1'b1;
                     state      <= START;
                  end else if (idx == IDX_LAST) begin
                     frame_done <= 1'b1;
                     state      <= DONE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
               START: begin
                  state <= WAIT;
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
                  to_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
`endif
               end
               WAIT: begin
                  if (core_done) begin
                     state <= STORE;
                  end
`ifdef GOERTZEL_SCHED_TIMEOUT_EN
                  else if (to_cnt == '0) begin
                     err   <= 1'b1;
                     idx   <= idx + 1'b1;
                     state <= SCAN;
                  end else begin
                     to_cnt <= to_cnt - 1'b1;
                  end
`endif
               end
               STORE: begin
                  t1_tab[idx_lo]    <= core_t1;
                  t2_tab[idx_lo]    <= core_t2;
                  res_valid[idx_lo] <= 1'b1;
                  idx               <= idx + 1'b1;
                  state             <= SCAN;
               end
               DONE: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge dsp_clk or posedge dsp_rst) begin
      if (dsp_rst) begin
         rd_t1 <= '0;
         rd_t2 <= '0;
      end else if (int'(rd_addr) < NUM_BINS) begin
         rd_t1 <= t1_tab[rd_addr];
         rd_t2 <= t2_tab[rd_addr];
      end else begin
         rd_t1 <= '0;
         rd_t2 <= '0;
      end
   end

endmodule

// File: tb/tb_goertzel_bin_scheduler.sv
// Directed bench for goertzel_bin_scheduler with a behavioural goertzel_core stand-in.
// Timeout scenario is exercised only when GOERTZEL_SCHED_TIMEOUT_EN is defined.
module tb_goertzel_bin_scheduler;

   logic        dsp_clk = 1'b0;
   logic        dsp_rst;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [15:0] cfg_coeff;
   logic [7:0]  bin_enable;
   logic        run;
   logic        abort;
   logic        busy;
   logic        frame_done;
   logic        core_start;
   logic [15:0] core_coeff;
   logic        core_done;
   logic [15:0] core_t1;
   logic [15:0] core_t2;
   logic [2:0]  rd_addr;
   logic [15:0] rd_t1;
   logic [15:0] rd_t2;
   logic [7:0]  res_valid;
   logic        err;

   goertzel_bin_scheduler dut (
      .dsp_clk    (dsp_clk),
      .dsp_rst    (dsp_rst),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_coeff  (cfg_coeff),
      .bin_enable (bin_enable),
      .run        (run),
      .abort      (abort),
      .busy       (busy),
      .frame_done (frame_done),
      .core_start (core_start),
      .core_coeff (core_coeff),
      .core_done  (core_done),
      .core_t1    (core_t1),
      .core_t2    (core_t2),
      .rd_addr    (rd_addr),
      .rd_t1      (rd_t1),
      .rd_t2      (rd_t2),
      .res_valid  (res_valid),
      .err        (err)
   );

   always #5 dsp_clk = ~dsp_clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Core stand-in: answers 10 cycles after core_start with t1=bin*0x100+1, t2=bin*0x100+2.
   // The bin is derived from the bench's own copy of the mask, not from the DUT.
   logic [7:0]  tb_mask = '0;
   int          nb_from = 0;
   int          cur_bin = 0;
   int          ccnt    = 0;
   bit          mute0   = 1'b0;
   int          n_start = 0;
   int          n_fdone = 0;
   logic [15:0] start_coeff [0:63];
   logic [15:0] done_coeff  = '0;

   function automatic int next_bin(input logic [7:0] m, input int from);
      for (int b = from; b < 8; b++) if (m[b]) return b;
      return 7;
   endfunction

   always @(negedge dsp_clk) begin
      core_done = 1'b0;
      if (core_start) begin
         start_coeff[n_start % 64] = core_coeff;
         n_start++;
         cur_bin = next_bin(tb_mask, nb_from);
         nb_from = cur_bin + 1;
         ccnt    = (mute0 && cur_bin == 0) ? 0 : 10;
      end else if (ccnt > 0) begin
         ccnt--;
         if (ccnt == 0) begin
            core_done  = 1'b1;
            core_t1    = 16'(cur_bin * 256 + 1);
            core_t2    = 16'(cur_bin * 256 + 2);
            done_coeff = core_coeff;
         end
      end
      if (frame_done) n_fdone++;
   end

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_coeff = d;
      @(negedge dsp_clk);
      cfg_we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [15:0] t1, output logic [15:0] t2);
      rd_addr = a;
      @(negedge dsp_clk);
      t1 = rd_t1; t2 = rd_t2;
   endtask

   task automatic start(input logic [7:0] m);
      tb_mask = m; nb_from = 0; bin_enable = m; run = 1'b1;
      @(negedge dsp_clk);
      run = 1'b0;
   endtask

   task automatic wait_fdone(input int max, input string tag);
      int k = 0;
      while (!frame_done && k < max) begin
         @(negedge dsp_clk);
         k++;
      end
      chk(tag, frame_done, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int s0, f0, cyc, k;
      logic [15:0] t1, t2;
      dsp_rst = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_coeff = 0; bin_enable = 0;
      run = 0; abort = 0; core_done = 0; core_t1 = 0; core_t2 = 0; rd_addr = 0;
      repeat (3) @(negedge dsp_clk);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_core_coeff", core_coeff, 0);
      chk("rst_rd_t1", rd_t1, 0);
      chk("rst_rd_t2", rd_t2, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_err", err, 0);
      dsp_rst = 1'b0;
      @(negedge dsp_clk);

      // two-bin frame
      wr(3'd0, 16'h2826);
      wr(3'd1, 16'h1882);
      s0 = n_start; f0 = n_fdone;
      start(8'h03);
      chk("t1_busy", busy, 1);
      wait_fdone(200, "t1_frame_done");
      repeat (3) @(negedge dsp_clk);
      chk("t1_starts", n_start - s0, 2);
      chk("t1_coeff_b0", start_coeff[s0 % 64], 16'h2826);
      chk("t1_coeff_b1", start_coeff[(s0 + 1) % 64], 16'h1882);
      chk("t1_res_valid", res_valid, 8'h03);
      chk("t1_fdones", n_fdone - f0, 1);
      chk("t1_busy_end", busy, 0);
      rd(3'd1, t1, t2);
      chk("t1_rd1_t1", t1, 16'h0101);
      chk("t1_rd1_t2", t2, 16'h0102);
      rd(3'd0, t1, t2);
      chk("t1_rd0_t1", t1, 16'h0001);
      rd(3'd5, t1, t2);
      chk("t1_rd5_t1", t1, 16'h0000);

      // empty mask: run cycle counts as cycle 1, frame_done expected in cycle 10
      s0 = n_start;
      tb_mask = 8'h00; nb_from = 0; bin_enable = 8'h00; run = 1'b1;
      cyc = 1;
      do begin
         @(negedge dsp_clk);
         run = 1'b0;
         cyc++;
      end while (!frame_done && cyc < 40);
      chk("t2_frame_done_cycle", cyc, 10);
      chk("t2_starts", n_start - s0, 0);
      chk("t2_res_valid", res_valid, 8'h00);

      // first and last bin only
      wr(3'd7, 16'h7777);
      s0 = n_start;
      start(8'h81);
      wait_fdone(200, "t3_frame_done");
      repeat (2) @(negedge dsp_clk);
      chk("t3_starts", n_start - s0, 2);
      chk("t3_coeff_b0", start_coeff[s0 % 64], 16'h2826);
      chk("t3_coeff_wait7", done_coeff, 16'h7777);
      chk("t3_res_valid", res_valid, 8'h81);
      rd(3'd7, t1, t2);
      chk("t3_rd7_t1", t1, 16'h0701);

      // abort during WAIT of bin 1
      s0 = n_start; f0 = n_fdone;
      start(8'h07);
      k = 0;
      while (n_start < s0 + 2 && k < 100) begin
         @(negedge dsp_clk);
         k++;
      end
      chk("t4_second_start", n_start - s0, 2);
      repeat (3) @(negedge dsp_clk);
      abort = 1'b1;
      @(negedge dsp_clk);
      abort = 1'b0;
      chk("t4_busy_after_abort", busy, 0);
      chk("t4_res_valid", res_valid, 8'h01);
      repeat (15) @(negedge dsp_clk);
      chk("t4_no_frame_done", n_fdone - f0, 0);
      chk("t4_busy_late_done", busy, 0);
      chk("t4_res_valid_late", res_valid, 8'h01);

      // run held through the frame, coefficient rewritten after bin 2 latched
      wr(3'd2, 16'h2222);
      s0 = n_start; f0 = n_fdone;
      tb_mask = 8'h04; nb_from = 0; bin_enable = 8'h04; run = 1'b1;
      k = 0;
      while (n_start == s0 && k < 100) begin
         @(negedge dsp_clk);
         k++;
      end
      wr(3'd2, 16'h3333);
      wait_fdone(200, "t5_frame_done");
      run = 1'b0;
      repeat (5) @(negedge dsp_clk);
      chk("t5_one_frame", n_fdone - f0, 1);
      chk("t5_one_start", n_start - s0, 1);
      chk("t5_old_coeff", done_coeff, 16'h2222);
      chk("t5_busy", busy, 0);
      start(8'h04);
      wait_fdone(200, "t5b_frame_done");
      @(negedge dsp_clk);
      chk("t5b_new_coeff", done_coeff, 16'h3333);
      rd(3'd2, t1, t2);
      chk("t5b_rd2_t2", t2, 16'h0202);

`ifdef GOERTZEL_SCHED_TIMEOUT_EN
      s0 = n_start;
      mute0 = 1'b1;
      start(8'h03);
      wait_fdone(6000, "t6_frame_done");
      mute0 = 1'b0;
      chk("t6_err", err, 1);
      chk("t6_res_valid", res_valid, 8'h02);
      chk("t6_starts", n_start - s0, 2);
      repeat (2) @(negedge dsp_clk);
      start(8'h00);
      chk("t6_err_cleared", err, 0);
      wait_fdone(50, "t6b_frame_done");
`else
      chk("t6_err_tied", err, 0);
`endif

      repeat (3) @(negedge dsp_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
